// File: rtl/ysyx_23060236_clint_pkg.sv
// rtl/ysyx_23060236_clint_pkg.sv - CLINT offsets, AXI response codes and FSM states
package ysyx_23060236_clint_pkg;

  localparam logic [15:0] CLINT_MTIME_LO_OFF = 16'hBFF8;
  localparam logic [15:0] CLINT_MTIME_HI_OFF = 16'hBFFC;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } clint_state_e;

endpackage

// File: rtl/ysyx_23060236_clint_mtime.sv
// rtl/ysyx_23060236_clint_mtime.sv - prescaled free-running 64-bit mtime counter
module ysyx_23060236_clint_mtime #(
  parameter int TICK_DIV = 1
) (
  input  logic        clock,
  input  logic        reset,
  output logic [63:0] mtime
);

  localparam int            PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  logic [PW-1:0] r_pre_cnt;
  logic [63:0]   r_mtime;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pre_cnt <= '0;
      r_mtime   <= '0;
    end else if (r_pre_cnt == PRE_MAX) begin
      r_pre_cnt <= '0;
      r_mtime   <= r_mtime + 64'd1;
    end else begin
      r_pre_cnt <= r_pre_cnt + 1'b1;
    end
  end

  assign mtime = r_mtime;

endmodule

// File: rtl/ysyx_23060236_clint.sv
// rtl/ysyx_23060236_clint.sv - AXI4-Lite read-only CLINT responder exposing mtime
module ysyx_23060236_clint
  import ysyx_23060236_clint_pkg::*;
#(
  parameter int          TICK_DIV     = 1,
  parameter int          RD_LATENCY   = 0,
  parameter logic [15:0] MTIME_LO_OFF = CLINT_MTIME_LO_OFF,
  parameter logic [15:0] MTIME_HI_OFF = CLINT_MTIME_HI_OFF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] clint_araddr,
  input  logic        clint_arvalid,
  output logic        clint_arready,
  output logic [31:0] clint_rdata,
  output logic [1:0]  clint_rresp,
  output logic        clint_rvalid,
  input  logic        clint_rready,
  output logic [63:0] mtime_o
);

  localparam int         WCNT_I    = (RD_LATENCY > 0) ? RD_LATENCY - 1 : 0;
  localparam logic [3:0] WCNT_INIT = WCNT_I[3:0];

  logic [63:0]  w_mtime;
  logic [13:0]  w_word;
  logic         w_is_lo;
  logic         w_is_hi;
  logic         w_ar_fire;
  logic         w_unused;

  clint_state_e r_state;
  logic [3:0]   r_wcnt;
  logic         r_snap_valid;
  logic [31:0]  r_hi_snap;
  logic         r_arready;
  logic         r_rvalid;
  logic [31:0]  r_rdata;
  logic [1:0]   r_rresp;

  ysyx_23060236_clint_mtime #(.TICK_DIV(TICK_DIV)) u_mtime (
    .clock (clock),
    .reset (reset),
    .mtime (w_mtime)
  );

  assign w_word    = clint_araddr[15:2];
  assign w_is_lo   = (w_word == MTIME_LO_OFF[15:2]);
  assign w_is_hi   = (w_word == MTIME_HI_OFF[15:2]);
  assign w_ar_fire = clint_arvalid & r_arready;
  assign w_unused  = ^{clint_araddr[31:16], clint_araddr[1:0]};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_wcnt       <= '0;
      r_snap_valid <= 1'b0;
      r_hi_snap    <= '0;
      r_arready    <= 1'b0;
      r_rvalid     <= 1'b0;
      r_rdata      <= '0;
      r_rresp      <= AXI_RESP_OKAY;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_ar_fire) begin
            r_arready <= 1'b0;
            // The lo read freezes the hi word so a following hi read cannot tear across a carry.
            if (w_is_lo) begin
              r_rdata      <= w_mtime[31:0];
              r_rresp      <= AXI_RESP_OKAY;
              r_hi_snap    <= w_mtime[63:32];
              r_snap_valid <= 1'b1;
            end else if (w_is_hi) begin
              r_rdata      <= r_snap_valid ? r_hi_snap : w_mtime[63:32];
              r_rresp      <= AXI_RESP_OKAY;
              r_snap_valid <= 1'b0;
            end else begin
              r_rdata <= '0;
              r_rresp <= AXI_RESP_SLVERR;
            end
            if (RD_LATENCY > 0) begin
              r_state <= ST_WAIT;
              r_wcnt  <= WCNT_INIT;
            end else begin
              r_state  <= ST_RESP;
              r_rvalid <= 1'b1;
            end
          end else begin
            r_arready <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (r_wcnt == 4'd0) begin
            r_state  <= ST_RESP;
            r_rvalid <= 1'b1;
          end else begin
            r_wcnt <= r_wcnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (clint_rready) begin
            r_rvalid  <= 1'b0;
            r_arready <= 1'b1;
            r_state   <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign clint_arready = r_arready;
  assign clint_rvalid  = r_rvalid;
  assign clint_rdata   = r_rdata;
  assign clint_rresp   = r_rresp;
  assign mtime_o       = w_mtime;

endmodule
